// File: rtl/fifo_rd_stream.sv
// Read-side FWFT adapter for the async FIFO. It prefetches into a 2-entry register
// buffer so a FIFO memory with registered read latency can still deliver one word per cycle.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [1:0]            occupancy
);

    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            occ_q, occ_d;

    logic                  pop_s;
    logic                  wr_s;
    logic                  rd_en_s;
    logic [2:0]            slots_s;

    // Read request and next-state logic. The m_ready -> rd_en path is combinational
    // and must be budgeted for timing: a read may issue into the slot freed by a pop.
    always_comb begin
        pop_s      = (occ_q != 2'd0) && m_ready;
        wr_s       = inflight_q;
        slots_s    = {1'b0, occ_q} + {2'b00, inflight_q};
        rd_en_s    = !rd_rst && !flush && !fifo_empty &&
                     ((slots_s < 3'd2) || ((slots_s == 3'd2) && pop_s));
        buf_d      = buf_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = inflight_q;
        occ_d      = occ_q;
        if (flush) begin
            head_d     = 1'b0;
            tail_d     = 1'b0;
            inflight_d = 1'b0;
            occ_d      = 2'd0;
        end else begin
            if (wr_s) begin
                buf_d[tail_q] = rd_data;
                tail_d        = ~tail_q;
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = ~head_q;
            end else begin
                head_d = head_q;
            end
            inflight_d = rd_en_s;
            occ_d      = occ_q + {1'b0, wr_s} - {1'b0, pop_s};
        end
    end

    // State registers; reset also zeroes the buffer so m_data reads 0 afterwards.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            buf_q[0]   <= {DATA_WIDTH{1'b0}};
            buf_q[1]   <= {DATA_WIDTH{1'b0}};
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            buf_q      <= buf_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
        end
    end

    assign rd_en     = rd_en_s;
    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = buf_q[head_q];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomised scoreboard bench: an upstream FIFO model feeds the DUT and records every word
// it hands out; a negedge monitor checks the stream, occupancy and read requests against it.
module tb_fifo_rd_stream;

    logic       rd_clk = 1'b0;
    logic       rd_rst;
    logic       fifo_empty;
    logic [7:0] rd_data;
    logic       rd_en;
    logic       flush;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic [1:0] occupancy;

    logic [7:0] fifo_q [$];
    logic [7:0] exp_q  [$];
    int         n_chk  = 0;
    int         n_pass = 0;
    bit         mon_en = 1'b0;
    bit         acc_seen = 1'b0;
    bit         issued = 1'b0;
    bit         zero_flag = 1'b0;

    fifo_rd_stream #(.DATA_WIDTH(8)) dut (
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .fifo_empty(fifo_empty),
        .rd_data   (rd_data),
        .rd_en     (rd_en),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .occupancy (occupancy)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: the FIFO answers last cycle's accepted read, then inputs change.
    task automatic step(input bit mr, input bit fl, input bit rs);
        @(posedge rd_clk);
        #1;
        if (acc_seen) begin
            rd_data = fifo_q.pop_front();
            exp_q.push_back(rd_data);
            issued = 1'b1;
        end else begin
            issued = 1'b0;
        end
        m_ready    = mr;
        flush      = fl;
        rd_rst     = rs;
        fifo_empty = (fifo_q.size() == 0);
        mon_en     = 1'b1;
    endtask

    // Monitor: exp_q holds every word read and not yet delivered; the newest one is
    // still in flight on rd_data when issued is set.
    always @(negedge rd_clk) begin
        int occ_m;
        int slots;
        bit pop_m;
        bit rd_en_m;
        if (mon_en) begin
            #2;
            slots   = exp_q.size();
            occ_m   = slots - (issued ? 1 : 0);
            pop_m   = (occ_m > 0) && m_ready;
            rd_en_m = !rd_rst && !flush && !fifo_empty &&
                      ((slots < 2) || ((slots == 2) && pop_m));
            chk("rd_en", 32'(rd_en), 32'(rd_en_m));
            chk("occupancy", 32'(occupancy), 32'(occ_m));
            chk("m_valid", 32'(m_valid), 32'(occ_m > 0));
            chk("slots_le_2", 32'(slots <= 2), 32'd1);
            if (occ_m > 0) begin
                chk("m_data", 32'(m_data), 32'(exp_q[0]));
                zero_flag = 1'b0;
            end else if (zero_flag) begin
                chk("m_data_after_reset", 32'(m_data), 32'd0);
            end
            if (rd_rst || flush) begin
                exp_q.delete();
                if (rd_rst) zero_flag = 1'b1;
            end else if (pop_m) begin
                void'(exp_q.pop_front());
            end
            acc_seen = rd_en && !fifo_empty;
        end
    end

    initial begin
        rd_rst     = 1'b1;
        flush      = 1'b0;
        m_ready    = 1'b0;
        rd_data    = 8'h00;
        fifo_empty = 1'b1;

        // Reset with a non-empty FIFO, then stream four words with m_ready held high.
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        repeat (3) step(1'b1, 1'b0, 1'b1);
        repeat (8) step(1'b1, 1'b0, 1'b0);

        // Backpressure: five words, sink stalled, then drained.
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'(8'h50 + i));
        repeat (14) step(1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b0);

        // Alternating m_ready with eight words.
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(i));
        for (int i = 0; i < 24; i++) step(((i % 2) == 0), 1'b0, 1'b0);

        // Flush while one word is buffered and the next is in flight.
        fifo_q.push_back(8'h60);
        fifo_q.push_back(8'h61);
        fifo_q.push_back(8'h62);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b0, 1'b0);

        // Single word into an idle stage.
        repeat (3) step(1'b1, 1'b0, 1'b0);
        fifo_q.push_back(8'hA5);
        repeat (6) step(1'b1, 1'b0, 1'b0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            if ((fifo_q.size() < 6) && ($urandom_range(0, 2) == 0)) begin
                fifo_q.push_back(8'($urandom_range(0, 255)));
            end
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 79) == 0));
        end
        repeat (6) step(1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer stage of the async FIFO. Sits in the rd_clk domain between the read pointer/empty logic plus the FIFO memory, and a downstream valid/ready stream sink.
- Converts the FIFO read interface into a first-word-fall-through (FWFT) stream. The interface is rd_en out, fifo_empty in, and rd_data in, with rd_data arriving one cycle after the read is accepted.
- A 2-entry output buffer with prefetch sustains one word per cycle with a registered-latency memory.

Parameters:
DATA_WIDTH, 8, width of FIFO data word and output stream data.

Ports:
rd_clk  input  1  read-domain clock; all state updates on rising edge.
rd_rst  input  1  synchronous, active-high reset.
fifo_empty  input  1  empty flag from FIFO read logic; a read is accepted only when low.
rd_data  input  DATA_WIDTH  FIFO memory read data; valid in the cycle after an accepted read.
rd_en  output  1  read request to FIFO read logic and memory.
flush  input  1  synchronous clear of buffered and in-flight data.
m_valid  output  1  output stream word valid.
m_data  output  DATA_WIDTH  output stream data (head of buffer).
m_ready  input  1  sink accepts the word when m_valid && m_ready.
occupancy  output  2  number of words held in the output buffer (0..2).

Behaviour:
- Reset (rd_rst=1 at a rising edge) clears the following:
  - occupancy=0, m_valid=0, m_data=0.
  - In-flight flag=0; head/tail pointers=0.
- rd_en is forced 0 combinationally while rd_rst=1. This applies regardless of fifo_empty, because the upstream empty flag resets low.
- Accepted read: rd_en && !fifo_empty. It sets the in-flight flag for the next cycle.
- Buffer write: while in-flight=1, rd_data is written at the tail on that rising edge. Tail advances by 1 modulo 2, and in-flight clears unless a new read was accepted in the same cycle.
- Pop: m_valid && m_ready. Head advances modulo 2.
- occupancy_next = occupancy + write − pop. Simultaneous write and pop leaves occupancy unchanged.
- m_valid = (occupancy != 0). m_data = buffer[head], sourced from registers only, with no combinational path from rd_data.
- Slots used = occupancy + in-flight (0..3 arithmetically, never exceeds 2 by construction).
- rd_en = !rd_rst && !flush && !fifo_empty && (slots_used < 2 || (slots_used == 2 && pop)).
  - The m_ready → rd_en path is combinational and is documented for timing.
  - Buffer overflow is impossible; verification asserts occupancy + in-flight ≤ 2 every cycle.
- Latency:
  - Word present in FIFO with buffer empty → m_valid high 2 cycles after fifo_empty goes low.
  - Cycle 0: rd_en. Cycle 1: capture. Cycle 2: m_valid.
- Throughput: with m_ready held high and FIFO non-empty, one word per cycle after initial fill, with no bubbles.
- Backpressure: with m_ready low, at most 2 words are fetched, then rd_en stays low. m_valid and m_data are held stable until pop.
- Ordering: words exit in exact FIFO read order; no duplication, no loss (except flush).
- flush=1 at an edge clears the following:
  - occupancy=0, in-flight=0, pointers=0.
  - The in-flight word is discarded. The FIFO pointer has already advanced, so that word is lost by design.
  - flush has priority over write and pop in the same cycle. rd_en=0 during flush.
- Reset mid-transfer: identical to flush, plus m_data is cleared to 0.
- fifo_empty rising while a read is in-flight: the in-flight word is still captured; no further reads.

Test Plan:
- Reset with fifo_empty=0 → rd_en=0 throughout reset; after release, occupancy=0 and m_valid=0 until the first capture.
- FIFO preloaded 0x11,0x22,0x33,0x44, m_ready=1 → rd_en high cycles 0–3; m_data 0x11,0x22,0x33,0x44 on cycles 2–5, m_valid continuous; rd_en falls when fifo_empty rises.
- FIFO holds 5 words, m_ready=0 → exactly 2 reads issued; occupancy=2, m_data=first word stable for 10 cycles; raising m_ready drains all 5 in order with rd_en re-asserting in the pop cycle.
- m_ready toggling 1,0,1,0 with FIFO of 8 words → output order 0..7 preserved, occupancy never >2, no dropped or duplicated words (scoreboard).
- flush asserted in the cycle after an accepted read with occupancy=1 → next cycle occupancy=0, m_valid=0, in-flight word absent from output; subsequent FIFO words stream normally.
- Single word 0xA5 written when idle → m_valid rises exactly 2 cycles after fifo_empty falls, m_data=0xA5; pop with m_ready=1 → occupancy 0, rd_en stays 0 while fifo_empty=1.
